// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use stall, redirect flush and iterative-divider hold control for the 5-stage pipeline
module hazard_ctrl #(
  parameter int DIV_LATENCY = 34,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid_i,
  input  logic [6:0]       id_opcode_i,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic             ex_valid_i,
  input  logic             ex_mem_read_i,
  input  logic [4:0]       ex_rd_i,
  input  logic             ex_redirect_i,
  input  logic             ex_is_div_i,
  output logic             pc_en_o,
  output logic             if_id_en_o,
  output logic             if_id_flush_o,
  output logic             id_ex_en_o,
  output logic             id_ex_bubble_o,
  output logic             ex_mem_bubble_o,
  output logic             div_start_o,
  output logic             stall_o,
  output logic             flush_o,
  output logic [CNT_W-1:0] stall_cnt_o
);
  localparam int CW = $clog2(DIV_LATENCY);
  typedef enum logic {IDLE, DIV_BUSY} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic uses_rs1, uses_rs2, lu, div_go, div_stall, redir, lu_stall;
  assign uses_rs1 = !(id_opcode_i inside {7'b0110111, 7'b0010111, 7'b1101111});
  assign uses_rs2 = id_opcode_i inside {7'b0110011, 7'b0100011, 7'b1100011, 7'b0101111};
  assign lu = id_valid_i & ex_valid_i & ex_mem_read_i & (ex_rd_i != 5'd0)
            & ((uses_rs1 & (id_rs1_i == ex_rd_i)) | (uses_rs2 & (id_rs2_i == ex_rd_i)));
  assign div_go    = !reset & (state == IDLE) & ex_valid_i & ex_is_div_i;
  assign div_stall = div_go | (!reset & (state == DIV_BUSY) & (cnt != '0));
  assign redir     = !reset & !div_stall & ex_redirect_i;
  assign lu_stall  = !reset & !div_stall & !ex_redirect_i & lu;
  assign pc_en_o         = !(div_stall | lu_stall);
  assign if_id_en_o      = !(div_stall | lu_stall);
  assign id_ex_en_o      = !div_stall;
  assign if_id_flush_o   = redir;
  assign id_ex_bubble_o  = redir | lu_stall;
  assign ex_mem_bubble_o = div_stall;
  assign div_start_o     = div_go;
  assign stall_o         = div_stall | lu_stall;
  assign flush_o         = redir;
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    if (state == IDLE) begin
      state_n = (ex_valid_i & ex_is_div_i) ? DIV_BUSY : IDLE;
      cnt_n   = (ex_valid_i & ex_is_div_i) ? CW'(DIV_LATENCY - 2) : cnt;
    end else begin
      state_n = (cnt != '0) ? DIV_BUSY : IDLE;
      cnt_n   = (cnt != '0) ? cnt - CW'(1) : cnt;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      stall_cnt_o <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (stall_o && stall_cnt_o != '1) stall_cnt_o <= stall_cnt_o + CNT_W'(1);
    end
  end
  // A redirecting instruction can never also be a divide.
  a_no_redirect_div: assert property (@(posedge clk) disable iff (reset) !(ex_redirect_i && ex_is_div_i));
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: randomized scoreboard bench for hazard_ctrl against an occupancy-based reference model
module tb_hazard_ctrl;
  localparam int LAT = 34;
  localparam int CW  = 8;
  localparam int SAT = (1 << CW) - 1;
  logic clk = 0, reset = 1;
  logic id_valid_i = 0, ex_valid_i = 0, ex_mem_read_i = 0, ex_redirect_i = 0, ex_is_div_i = 0;
  logic [6:0] id_opcode_i = 0;
  logic [4:0] id_rs1_i = 0, id_rs2_i = 0, ex_rd_i = 0;
  logic pc_en_o, if_id_en_o, if_id_flush_o, id_ex_en_o, id_ex_bubble_o, ex_mem_bubble_o;
  logic div_start_o, stall_o, flush_o;
  logic [CW-1:0] stall_cnt_o;
  hazard_ctrl #(.DIV_LATENCY(LAT), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .id_valid_i(id_valid_i), .id_opcode_i(id_opcode_i),
    .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .ex_valid_i(ex_valid_i), .ex_mem_read_i(ex_mem_read_i),
    .ex_rd_i(ex_rd_i), .ex_redirect_i(ex_redirect_i), .ex_is_div_i(ex_is_div_i), .pc_en_o(pc_en_o),
    .if_id_en_o(if_id_en_o), .if_id_flush_o(if_id_flush_o), .id_ex_en_o(id_ex_en_o),
    .id_ex_bubble_o(id_ex_bubble_o), .ex_mem_bubble_o(ex_mem_bubble_o), .div_start_o(div_start_o),
    .stall_o(stall_o), .flush_o(flush_o), .stall_cnt_o(stall_cnt_o)
  );
  always #5 clk = ~clk;
  typedef struct {logic [8:0] ctl; int cnt; bit chk;} exp_t;
  exp_t q[$];
  int n_cmp = 0, n_bad = 0;
  bit m_busy = 0;
  int m_k = 0, m_sc = 0;
  localparam logic [6:0] OPS [12] = '{7'b0110011, 7'b0100011, 7'b1100011, 7'b0101111, 7'b0110111, 7'b0010111,
                                      7'b1101111, 7'b0000011, 7'b0010011, 7'b1100111, 7'b0001111, 7'b1110011};
  // ctl = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, ex_mem_bubble, div_start, stall, flush}
  task automatic step(input logic r, input logic iv, input logic [6:0] op, input logic [4:0] rs1, rs2,
                      input logic ev, mr, input logic [4:0] rd, input logic rdr, dv);
    exp_t e;
    int kn;
    bit u1, u2, lu, ds;
    @(posedge clk);
    #1;
    reset = r; id_valid_i = iv; id_opcode_i = op; id_rs1_i = rs1; id_rs2_i = rs2;
    ex_valid_i = ev; ex_mem_read_i = mr; ex_rd_i = rd; ex_redirect_i = rdr; ex_is_div_i = dv;
    e.cnt = m_sc;
    e.chk = !r;
    if (r) begin
      e.ctl = 9'b110100000;
      m_busy = 0; m_k = 0; m_sc = 0;
    end else begin
      kn = m_busy ? m_k : ((ev && dv) ? 1 : 0);
      ds = kn >= 1 && kn < LAT;
      u1 = !(op inside {7'b0110111, 7'b0010111, 7'b1101111});
      u2 = op inside {7'b0110011, 7'b0100011, 7'b1100011, 7'b0101111};
      lu = iv && ev && mr && rd != 0 && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
      if (ds) e.ctl = {6'b000001, !m_busy && kn == 1, 2'b10};
      else if (rdr) e.ctl = 9'b111110001;
      else if (lu) e.ctl = 9'b000110010;
      else e.ctl = 9'b110100000;
      m_busy = ds;
      m_k = kn + 1;
      if (e.ctl[1]) m_sc = (m_sc < SAT) ? m_sc + 1 : SAT;
    end
    q.push_back(e);
  endtask
  task automatic idle_cyc(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 7'b0010011, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic div_cyc(input int n);
    for (int i = 0; i < n; i++) step(0, 1, 7'b0110011, 5'd3, 5'd4, 1, 0, 5'd9, 0, 1);
  endtask
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        x = q.pop_front();
        n_cmp++;
        if ({pc_en_o, if_id_en_o, if_id_flush_o, id_ex_en_o, id_ex_bubble_o, ex_mem_bubble_o,
             div_start_o, stall_o, flush_o} !== x.ctl) begin
          n_bad++;
          $display("FAIL ctl @%0t got %b exp %b", $time, {pc_en_o, if_id_en_o, if_id_flush_o, id_ex_en_o,
                   id_ex_bubble_o, ex_mem_bubble_o, div_start_o, stall_o, flush_o}, x.ctl);
        end
        if (x.chk) begin
          n_cmp++;
          if (stall_cnt_o !== CW'(x.cnt)) begin
            n_bad++;
            $display("FAIL stall_cnt @%0t got %0d exp %0d", $time, stall_cnt_o, x.cnt);
          end
        end
      end
    end
  end
  initial begin
    logic iv, ev, mr, rdr, dv, r;
    logic [4:0] rs1, rs2, rd;
    logic [6:0] op;
    int pick;
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 7'b0110011, 5'd5, 5'd1, 1, 1, 5'd5, 0, 0);
    idle_cyc(2);
    step(0, 1, 7'b0110011, 5'd5, 5'd1, 1, 1, 5'd5, 0, 0);
    step(0, 1, 7'b0110011, 5'd5, 5'd1, 0, 0, 5'd0, 0, 0);
    step(0, 1, 7'b0100011, 5'd2, 5'd5, 1, 1, 5'd5, 0, 0);
    step(0, 1, 7'b0110111, 5'd5, 5'd5, 1, 1, 5'd5, 0, 0);
    step(0, 1, 7'b0010011, 5'd3, 5'd5, 1, 1, 5'd5, 0, 0);
    step(0, 1, 7'b0110011, 5'd0, 5'd0, 1, 1, 5'd5, 0, 0);
    step(0, 1, 7'b0110011, 5'd0, 5'd0, 1, 1, 5'd0, 0, 0);
    step(0, 0, 7'b0110011, 5'd5, 5'd1, 1, 1, 5'd5, 0, 0);
    step(0, 1, 7'b0110011, 5'd5, 5'd1, 1, 1, 5'd5, 1, 0);
    idle_cyc(1);
    div_cyc(LAT);
    idle_cyc(2);
    div_cyc(2 * LAT);
    step(0, 1, 7'b0110011, 5'd5, 5'd1, 1, 1, 5'd5, 0, 0);
    idle_cyc(1);
    div_cyc(10);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle_cyc(3);
    div_cyc(LAT);
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 199) == 0);
      iv = ($urandom_range(0, 9) != 0);
      op = OPS[$urandom_range(0, 11)];
      rs1 = 5'($urandom_range(0, 7));
      rs2 = 5'($urandom_range(0, 7));
      rd = 5'($urandom_range(0, 7));
      ev = ($urandom_range(0, 7) != 0);
      pick = $urandom_range(0, 99);
      dv = m_busy || pick < 4;
      if (m_busy) ev = 1;
      rdr = !dv && pick >= 4 && pick < 24;
      mr = !dv && pick >= 24 && pick < 70;
      step(r, iv, op, rs1, rs2, ev, mr, rd, rdr, dv);
    end
    idle_cyc(1);
    @(posedge clk);
    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain got %0d pending exp 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
